serial_subtractor: RTL

Bit-serial subtractor computing DIFF = A − B, LSB first, one bit per clock, with a start/done handshake. It is the inverse-direction companion to the combinational adder cells and the small-area arithmetic unit for counter and cursor decrement paths in the LCD datapath. The per-bit difference and borrow come from two half-subtractor cells chained into a full subtractor. A single borrow flop carries between bits.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_half_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller states (IDLE -> RUN -> DONE -> IDLE)
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Gate-level half subtractor cell, companion to the adder cells.
//   X  : minuend bit
//   Y  : subtrahend bit
//   D  : difference bit, X ^ Y
//   Bo : borrow out, ~X & Y
module half_subtractor (
  input  logic X,
  input  logic Y,
  output logic D,
  output logic Bo
);

  wire x_n;

  xor g_diff (D, X, Y);
  not g_inv  (x_n, X);
  and g_brw  (Bo, x_n, Y);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, processed LSB first, one bit per clock.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request, sampled only while idle
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out/overflow are fresh
//   diff       : a - b modulo 2^WIDTH
//   borrow_out : 1 when unsigned a < b
//   overflow   : signed two's-complement overflow of a - b
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // One extra counter bit keeps WIDTH=1 legal; RUN exits at LAST so it never wraps.
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             a_msb, b_msb;
  logic             hs1_d, hs1_bo, hs2_bo;
  logic             bit_d, bit_bout;

  // Full subtractor: first cell handles a0 - b0, second subtracts the incoming borrow.
  half_subtractor u_hs_ab (
    .X  (a_sr[0]),
    .Y  (b_sr[0]),
    .D  (hs1_d),
    .Bo (hs1_bo)
  );

  half_subtractor u_hs_bin (
    .X  (hs1_d),
    .Y  (borrow_q),
    .D  (bit_d),
    .Bo (hs2_bo)
  );

  assign bit_bout = hs1_bo | hs2_bo;

  // Result register after this cycle's bit enters at the MSB; written this way
  // so it stays legal when WIDTH=1.
  always_comb begin
    res_shift            = res_sr >> 1;
    res_shift[WIDTH-1]   = bit_d;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE after one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Datapath: operand capture, per-bit shifting, and result publication on the
  // final bit. Published outputs are only touched on the edge entering DONE, so a
  // partial result is never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      borrow_q   <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        ST_RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= res_shift;
          borrow_q <= bit_bout;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff       <= res_shift;
            borrow_out <= bit_bout;
            overflow   <= (a_msb ^ b_msb) & (res_shift[WIDTH-1] ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
